// File: rtl/mcs4_clock_gen_pkg.sv
// Shared definitions for the MCS-4 two-phase clock generator.
// Holds the clock FSM state encoding and the default phase widths, so the
// generator and the board-level top agree on both.
package mcs4_clock_gen_pkg;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_P1   = 3'd1,
        ST_G12  = 3'd2,
        ST_P2   = 3'd3,
        ST_G21  = 3'd4
    } clk_state_e;

    localparam int DEF_CLK1_W  = 19;
    localparam int DEF_GAP12   = 15;
    localparam int DEF_CLK2_W  = 19;
    localparam int DEF_GAP21   = 15;
    localparam int DEF_POC_PER = 64;

    // A state lasting w cycles is entered with its counter at w-1 and is
    // left on the cycle the counter reads zero.
    function automatic logic [7:0] load_val(input int w);
        return 8'(w - 1);
    endfunction

endpackage

// File: rtl/mcs4_clock_gen_poc_stretch.sv
// Power-on-clear stretcher: holds poc_pad high after reset until POC_PER
// clock periods have completed, then releases it for good.
// Ports:
//   sysclk      system clock
//   rst_n       asynchronous active-low reset
//   period_end  one-cycle pulse on the last cycle of every clock period
//   poc_pad     power-on clear, active high
module mcs4_clock_gen_poc_stretch
    import mcs4_clock_gen_pkg::*;
#(
    parameter int POC_PER = DEF_POC_PER
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic period_end,
    output logic poc_pad
);

    localparam logic [15:0] LAST_CNT = 16'(POC_PER - 1);

    logic [15:0] per_cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= 16'd0;
            poc_pad <= 1'b1;
        end else if (poc_pad && period_end) begin
            // The final period_end drops poc_pad on the following cycle;
            // once low it stays low until the next reset.
            if (per_cnt == LAST_CNT) begin
                poc_pad <= 1'b0;
            end else begin
                per_cnt <= per_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/mcs4_clock_gen.sv
// Two-phase non-overlapping clock generator for the 4004 timing stage, with
// power-on clear and run/halt/single-step debug control. Halting only ever
// happens at an instruction boundary: the end of the period whose phase-2
// saw SYNC high.
//
// state | meaning
// ------+----------------------------------------------------------
// P1    | clk1_pad high for CLK1_W cycles (reset state, counter 0)
// G12   | both clocks low for GAP12 cycles
// P2    | clk2_pad high for CLK2_W cycles; SYNC sampled here
// G21   | both clocks low for GAP21 cycles; boundary decision at end
// HALT  | clocks stopped at an instruction boundary
//
// Ports:
//   sysclk      system clock, all state on its rising edge
//   rst_n       asynchronous active-low reset
//   run         1 = free-run, 0 = halt at the next instruction boundary
//   step_req    rising edge while halted runs one instruction cycle
//   sync_pad    SYNC from the timing generator
//   clk1_pad    phase-1 clock
//   clk2_pad    phase-2 clock
//   poc_pad     power-on clear, active high
//   halted      clocks stopped at an instruction boundary
//   step_ack    one-cycle pulse when a single step completes
//   period_end  one-cycle pulse on the last cycle of every period
module mcs4_clock_gen
    import mcs4_clock_gen_pkg::*;
#(
    parameter int CLK1_W  = DEF_CLK1_W,
    parameter int GAP12   = DEF_GAP12,
    parameter int CLK2_W  = DEF_CLK2_W,
    parameter int GAP21   = DEF_GAP21,
    parameter int POC_PER = DEF_POC_PER
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic run,
    input  logic step_req,
    input  logic sync_pad,
    output logic clk1_pad,
    output logic clk2_pad,
    output logic poc_pad,
    output logic halted,
    output logic step_ack,
    output logic period_end
);

    clk_state_e state_q, state_nxt;
    logic [7:0] cnt_q, cnt_nxt;
    logic       sync_flag_q;
    logic       stepping_q;
    logic       step_req_q;
    logic       tc;
    logic       step_rise;
    logic       go_halt;
    logic       step_start;

    assign tc        = (cnt_q == 8'd0);
    assign step_rise = step_req & ~step_req_q;

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q - 8'd1;
        go_halt    = 1'b0;
        step_start = 1'b0;
        unique case (state_q)
            ST_P1: begin
                // P1 with clk1_pad still low only happens on the first edge
                // after reset: start a full-width pulse from here.
                if (!clk1_pad) begin
                    cnt_nxt = load_val(CLK1_W);
                end else if (tc) begin
                    state_nxt = ST_G12;
                    cnt_nxt   = load_val(GAP12);
                end
            end
            ST_G12: begin
                if (tc) begin
                    state_nxt = ST_P2;
                    cnt_nxt   = load_val(CLK2_W);
                end
            end
            ST_P2: begin
                if (tc) begin
                    state_nxt = ST_G21;
                    cnt_nxt   = load_val(GAP21);
                end
            end
            ST_G21: begin
                if (tc) begin
                    if (!poc_pad && sync_flag_q && !run) begin
                        state_nxt = ST_HALT;
                        cnt_nxt   = 8'd0;
                        go_halt   = 1'b1;
                    end else begin
                        state_nxt = ST_P1;
                        cnt_nxt   = load_val(CLK1_W);
                    end
                end
            end
            ST_HALT: begin
                cnt_nxt = cnt_q;
                // run wins over a simultaneous step request
                if (run) begin
                    state_nxt = ST_P1;
                    cnt_nxt   = load_val(CLK1_W);
                end else if (step_rise) begin
                    state_nxt  = ST_P1;
                    cnt_nxt    = load_val(CLK1_W);
                    step_start = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_P1;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_P1;
            cnt_q       <= 8'd0;
            sync_flag_q <= 1'b0;
            stepping_q  <= 1'b0;
            step_req_q  <= 1'b0;
            clk1_pad    <= 1'b0;
            clk2_pad    <= 1'b0;
            halted      <= 1'b0;
            step_ack    <= 1'b0;
            period_end  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            step_req_q <= step_req;
            // Both clocks decode from the one next-state value, so they can
            // never be high together.
            clk1_pad   <= (state_nxt == ST_P1);
            clk2_pad   <= (state_nxt == ST_P2);
            halted     <= (state_nxt == ST_HALT);
            period_end <= (state_nxt == ST_G21) && (cnt_nxt == 8'd0);
            step_ack   <= go_halt && stepping_q;

            if ((state_q == ST_G21) && tc) begin
                sync_flag_q <= 1'b0;
            end else if ((state_q == ST_P2) && sync_pad) begin
                sync_flag_q <= 1'b1;
            end

            // run=1 at any time turns a pending step back into free-running
            if (run || go_halt) begin
                stepping_q <= 1'b0;
            end else if (step_start) begin
                stepping_q <= 1'b1;
            end
        end
    end

    mcs4_clock_gen_poc_stretch #(
        .POC_PER(POC_PER)
    ) u_poc_stretch (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .period_end(period_end),
        .poc_pad   (poc_pad)
    );

endmodule
